// File: rtl/bitcoin_nonce_scheduler.sv
// rtl/bitcoin_nonce_scheduler.sv - Bitcoin double-SHA-256 nonce sweep sequencer for a shared core
//
// Purpose: drives one single-block SHA-256 core through a midstate pass and
// then two passes per nonce (header block 2, then hash-of-hash). Streams
// word 0 of each final digest to a valid/ready result sink.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, header,          job request (sampled in IDLE), 20-word header,
//   nonce_base                first nonce value
//   busy, done              job in progress, one-cycle completion pulse
//   core_start, core_done   core handshake (one-cycle pulses)
//   core_msg, core_h_in     16-word message and 8-word chaining value to core
//   core_h_out              8-word digest from core
//   res_valid, res_ready    result handshake
//   res_index, res_nonce,   nonce index, nonce value and digest word 0
//   res_hash
module bitcoin_nonce_scheduler #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [639:0] header,
  input  logic [31:0]  nonce_base,
  output logic         busy,
  output logic         done,
  output logic         core_start,
  input  logic         core_done,
  output logic [511:0] core_msg,
  output logic [255:0] core_h_in,
  input  logic [255:0] core_h_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [15:0]  res_index,
  output logic [31:0]  res_nonce,
  output logic [31:0]  res_hash
);

  typedef enum logic [3:0] {
    IDLE, MID_GO, MID_WAIT, P1_GO, P1_WAIT, P2_GO, P2_WAIT, EMIT, FIN
  } state_t;

  // Word 0 sits in the least significant 32 bits.
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [15:0] LAST_N = 16'(NUM_NONCES - 1);

  state_t         state_q, state_d;
  logic [607:0]   hdr_q, hdr_d;        // header word 19 is replaced by the nonce
  logic [31:0]    base_q, base_d;
  logic [15:0]    n_q, n_d;
  logic [255:0]   mid_q, mid_d;
  logic [255:0]   h1_q, h1_d;
  logic           settle_q, settle_d;
  logic           res_valid_q, res_valid_d;
  logic [15:0]    res_index_q, res_index_d;
  logic [31:0]    res_nonce_q, res_nonce_d;
  logic [31:0]    res_hash_q, res_hash_d;

  logic [31:0]    nonce;
  logic           unused_hdr_word19;

  assign nonce             = base_q + {16'h0000, n_q};
  assign unused_hdr_word19 = ^header[639:608];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      base_q      <= '0;
      n_q         <= '0;
      mid_q       <= '0;
      h1_q        <= '0;
      settle_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_nonce_q <= '0;
      res_hash_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      base_q      <= base_d;
      n_q         <= n_d;
      mid_q       <= mid_d;
      h1_q        <= h1_d;
      settle_q    <= settle_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_nonce_q <= res_nonce_d;
      res_hash_q  <= res_hash_d;
    end
  end

  // The MID and P1 waits linger one extra cycle after core_done (settle_q)
  // so the following GO never pulses core_start in the cycle right after
  // core_done. The P2 path gets the same gap from EMIT.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    base_d      = base_q;
    n_d         = n_q;
    mid_d       = mid_q;
    h1_d        = h1_q;
    settle_d    = settle_q;
    res_valid_d = res_valid_q;
    res_index_d = res_index_q;
    res_nonce_d = res_nonce_q;
    res_hash_d  = res_hash_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d   = header[607:0];
          base_d  = nonce_base;
          n_d     = '0;
          state_d = MID_GO;
        end
      end
      MID_GO: state_d = MID_WAIT;
      MID_WAIT: begin
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = P1_GO;
        end else if (core_done) begin
          mid_d    = core_h_out;
          settle_d = 1'b1;
        end
      end
      P1_GO: state_d = P1_WAIT;
      P1_WAIT: begin
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = P2_GO;
        end else if (core_done) begin
          h1_d     = core_h_out;
          settle_d = 1'b1;
        end
      end
      P2_GO: state_d = P2_WAIT;
      P2_WAIT: begin
        if (core_done) begin
          res_hash_d  = core_h_out[31:0];
          res_index_d = n_q;
          res_nonce_d = nonce;
          res_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (n_q == LAST_N) begin
            state_d = FIN;
          end else begin
            n_d     = n_q + 16'd1;
            state_d = P1_GO;   // midstate is reused for every nonce
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == FIN);
    core_start = (state_q == MID_GO) || (state_q == P1_GO) || (state_q == P2_GO);
    core_msg   = '0;
    core_h_in  = '0;
    case (state_q)
      MID_GO, MID_WAIT: begin
        core_msg  = hdr_q[511:0];
        core_h_in = IV;
      end
      P1_GO, P1_WAIT: begin
        core_msg  = {32'h00000280, 320'h0, 32'h80000000, nonce, hdr_q[607:512]};
        core_h_in = mid_q;
      end
      P2_GO, P2_WAIT: begin
        core_msg  = {32'h00000100, 192'h0, 32'h80000000, h1_q};
        core_h_in = IV;
      end
      default: begin
        core_msg  = '0;
        core_h_in = '0;
      end
    endcase
  end

  assign res_valid = res_valid_q;
  assign res_index = res_index_q;
  assign res_nonce = res_nonce_q;
  assign res_hash  = res_hash_q;

  // A core_done outside a WAIT state means the core and scheduler disagree.
  a_core_done_in_wait: assert property (@(posedge clk) disable iff (!reset_n)
    core_done |-> (state_q == MID_WAIT || state_q == P1_WAIT || state_q == P2_WAIT));

endmodule
